// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared constants and state encoding for the HI/LO multiply/divide unit
//
// Purpose: op encodings, FSM state type and constants, default sizes and the
// divide-by-zero quotient pattern used by mult_div_unit and its helpers.
// Ports: none (package).
package mdu_pkg;

   localparam int WIDTH_DEFAULT = 32;
   localparam int ITERS_DEFAULT = WIDTH_DEFAULT;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MADD  = 3'd4;
   localparam logic [2:0] OP_MADDU = 3'd5;

   typedef logic [1:0] state_t;
   localparam state_t IDLE   = 2'd0;
   localparam state_t RUN    = 2'd1;
   localparam state_t FINISH = 2'd2;

   // Quotient written to LO on divide by zero (sliced to the operand width);
   // HI receives the original dividend.
   localparam logic [63:0] DIV0_LO_FILL = '1;

endpackage

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - combinational two's-complement magnitude/sign correction
//
// Purpose: conditionally negates two WIDTH-bit lanes, either independently or
// as one 2*WIDTH-bit value {a_in,b_in} when wide=1 (products).
// Ports:
//   a_in, b_in   : input  lanes (a is the upper half in wide mode)
//   neg_a, neg_b : negate lane a / lane b (wide mode uses neg_a for both)
//   wide         : treat {a_in,b_in} as a single value
//   a_out, b_out : corrected lanes
module mdu_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             neg_a,
   input  logic             neg_b,
   input  logic             wide,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out
);

   logic [2*WIDTH-1:0] joint_in;
   logic [2*WIDTH-1:0] joint_neg;

   assign joint_in  = {a_in, b_in};
   assign joint_neg = -joint_in;

   always_comb begin
      a_out = a_in;
      b_out = b_in;
      if (wide) begin
         {a_out, b_out} = neg_a ? joint_neg : joint_in;
      end else begin
         a_out = neg_a ? -a_in : a_in;
         b_out = neg_b ? -b_in : b_in;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative HI/LO multiply/divide unit with start/busy/done handshake
//
// Purpose: MULT/MULTU/DIV/DIVU (plus MADD/MADDU when MDU_MADD_EN is defined)
// on register-file operands, one shift/add or shift/subtract step per cycle.
// Optional feature macro: MDU_MADD_EN (accumulate into {hi,lo}).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, op         : request and operation, sampled only in IDLE
//   rs_data, rt_data  : operands A and B
//   hi_we, lo_we      : MTHI/MTLO strobes, honoured only in IDLE
//   wdata             : MTHI/MTLO data
//   busy, done        : operation in progress / one-cycle completion pulse
//   hi, lo            : architectural HI/LO registers
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int ITERS = WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(ITERS + 1);

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] p;        // {remainder/upper product, quotient/lower product}
   logic [WIDTH-1:0]   b_q;      // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   rs_q;     // raw dividend, needed for the divide-by-zero result
   logic               div_q, div0_q, neg_a_q, neg_b_q, done_q;
   logic [WIDTH-1:0]   hi_q, lo_q;

   logic               legal, signed_op, div_op, accept, res_neg;
   logic [WIDTH-1:0]   rs_mag, rt_mag, res_hi, res_lo;
   logic [WIDTH:0]     mul_sum, div_trial;
   logic [2*WIDTH-1:0] mul_next, div_next;

`ifdef MDU_MADD_EN
   logic madd_q;
   assign legal = (op <= OP_MADDU);
`else
   assign legal = (op <= OP_DIVU);
`endif

   assign signed_op = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
   assign div_op    = (op == OP_DIV) || (op == OP_DIVU);
   assign accept    = (state == IDLE) && start && legal;

   mdu_sign_fix #(.WIDTH(WIDTH)) u_operand_fix (
      .a_in  (rs_data),
      .b_in  (rt_data),
      .neg_a (signed_op & rs_data[WIDTH-1]),
      .neg_b (signed_op & rt_data[WIDTH-1]),
      .wide  (1'b0),
      .a_out (rs_mag),
      .b_out (rt_mag)
   );

   // Products negate as one 2*WIDTH value; for divides the remainder follows
   // the dividend sign and the quotient follows signA^signB.
   assign res_neg = neg_a_q ^ neg_b_q;

   mdu_sign_fix #(.WIDTH(WIDTH)) u_result_fix (
      .a_in  (p[2*WIDTH-1:WIDTH]),
      .b_in  (p[WIDTH-1:0]),
      .neg_a (div_q ? neg_a_q : res_neg),
      .neg_b (res_neg),
      .wide  (~div_q),
      .a_out (res_hi),
      .b_out (res_lo)
   );

   // Shift/add multiply: add multiplicand into the upper half when the
   // multiplier LSB is set, then shift the whole register right.
   assign mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, b_q} : '0);
   assign mul_next = {mul_sum, p[WIDTH-1:1]};

   // Restoring divide: the partial remainder is always below the divisor, so
   // the shifted-in trial fits in WIDTH+1 bits and its MSB flags a borrow.
   assign div_trial = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]} - {1'b0, b_q};
   assign div_next  = div_trial[WIDTH] ? {p[2*WIDTH-2:0], 1'b0}
                                       : {div_trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         p       <= '0;
         b_q     <= '0;
         rs_q    <= '0;
         div_q   <= 1'b0;
         div0_q  <= 1'b0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
`ifdef MDU_MADD_EN
         madd_q  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (hi_we) hi_q <= wdata;
               if (lo_we) lo_q <= wdata;
               if (accept) begin
                  state   <= RUN;
                  cnt     <= '0;
                  div_q   <= div_op;
                  div0_q  <= (rt_data == '0);
                  neg_a_q <= signed_op & rs_data[WIDTH-1];
                  neg_b_q <= signed_op & rt_data[WIDTH-1];
                  rs_q    <= rs_data;
`ifdef MDU_MADD_EN
                  madd_q  <= (op == OP_MADD) || (op == OP_MADDU);
`endif
                  if (div_op) begin
                     p   <= {{WIDTH{1'b0}}, rs_mag};
                     b_q <= rt_mag;
                  end else begin
                     p   <= {{WIDTH{1'b0}}, rt_mag};
                     b_q <= rs_mag;
                  end
               end
            end
            RUN: begin
               p   <= div_q ? div_next : mul_next;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(ITERS - 1)) state <= FINISH;
            end
            FINISH: begin
               state  <= IDLE;
               cnt    <= '0;
               done_q <= 1'b1;
               if (div_q && div0_q) begin
                  hi_q <= rs_q;
                  lo_q <= DIV0_LO_FILL[WIDTH-1:0];
`ifdef MDU_MADD_EN
               end else if (madd_q) begin
                  {hi_q, lo_q} <= {hi_q, lo_q} + {res_hi, res_lo};
`endif
               end else begin
                  hi_q <= res_hi;
                  lo_q <= res_lo;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit (vector table + scoreboard)
module tb_mult_div_unit;

   localparam int W   = 32;
   localparam int LAT = 33;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [2:0]    op = 3'd0;
   logic [W-1:0]  rs_data = '0;
   logic [W-1:0]  rt_data = '0;
   logic          hi_we = 1'b0;
   logic          lo_we = 1'b0;
   logic [W-1:0]  wdata = '0;
   logic          busy, done;
   logic [W-1:0]  hi, lo;

   always #5 clk = ~clk;

   mult_div_unit dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .hi_we   (hi_we),
      .lo_we   (lo_we),
      .wdata   (wdata),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, ehi, elo;
   } vec_t;

   typedef struct {
      logic [31:0] ehi, elo;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[11];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] mh, output logic [31:0] ml);
      longint sa, sbv, q, rm;
      logic [63:0] r;
      sa  = $signed(a);
      sbv = $signed(b);
      mh = '0;
      ml = '0;
      case (o)
         3'd0: begin r = sa * sbv; mh = r[63:32]; ml = r[31:0]; end
         3'd1: begin r = {32'b0, a} * {32'b0, b}; mh = r[63:32]; ml = r[31:0]; end
         3'd2: begin
            if (b == 0) begin mh = a; ml = '1; end
            else begin q = sa / sbv; rm = sa % sbv; ml = q[31:0]; mh = rm[31:0]; end
         end
         default: begin
            if (b == 0) begin mh = a; ml = '1; end
            else begin ml = a / b; mh = a % b; end
         end
      endcase
   endfunction

   task automatic push(input logic [31:0] ehi, input logic [31:0] elo);
      exp_t e;
      e.ehi = ehi;
      e.elo = elo;
      sb.push_back(e);
   endtask

   // Drives a request and returns just after the accepting edge.
   task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      start   = 1'b1;
      op      = o;
      rs_data = a;
      rt_data = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("accept_busy", busy, 1);
      chk("done_pulse_low", done, 0);
   endtask

   // Waits for done (bounded); pre = edges already elapsed since accept.
   task automatic finish_op(input string name, input int pre);
      int   cyc;
      bit   seen;
      bit   busy_ok;
      exp_t e;
      cyc = pre;
      seen = 0;
      busy_ok = 1;
      while (!seen && cyc < LAT + 8) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done) seen = 1;
         else if (!busy) busy_ok = 0;
      end
      chk({name, "_latency"}, cyc, LAT);
      chk({name, "_busy_held"}, busy_ok, 1);
      chk({name, "_busy_clear"}, busy, 0);
      e = sb.pop_front();
      chk({name, "_hi"}, hi, e.ehi);
      chk({name, "_lo"}, lo, e.elo);
   endtask

   // Expects no done and no busy for a while (ignored requests).
   task automatic quiet(input string name, input int n);
      bit clean;
      clean = 1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) clean = 0;
      end
      chk({name, "_quiet"}, clean, 1);
   endtask

   initial begin
      logic [31:0] mh, ml, ra, rb;
      logic [2:0]  ro;

      vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[1]  = '{3'd0, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{3'd3, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
      vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5]  = '{3'd1, 32'd6,        32'd7,        32'd0,        32'd42};
      vecs[6]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      vecs[7]  = '{3'd3, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999};
      vecs[8]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[9]  = '{3'd2, 32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'hFFFFFFFF};
      vecs[10] = '{3'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_hi", hi, 0);
      chk("reset_lo", lo, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table vectors, issued back-to-back as soon as done is seen
      for (int i = 0; i < 11; i++) begin
         push(vecs[i].ehi, vecs[i].elo);
         start_op(vecs[i].op, vecs[i].a, vecs[i].b);
         finish_op($sformatf("vec%0d", i), 0);
      end

      // Random vectors against the arithmetic model
      for (int i = 0; i < 8; i++) begin
         ro = 3'($urandom_range(0, 3));
         ra = $urandom;
         rb = (i == 3) ? 32'd0 : ((i[0]) ? 32'($urandom_range(1, 50)) : $urandom);
         model(ro, ra, rb, mh, ml);
         push(mh, ml);
         start_op(ro, ra, rb);
         finish_op($sformatf("rnd%0d", i), 0);
      end

      // start and MTHI while busy are both ignored
      push(32'd0, 32'd42);
      start_op(3'd1, 32'd6, 32'd7);
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; op = 3'd3; rs_data = 32'd100; rt_data = 32'd3;
      hi_we = 1'b1; wdata = 32'h1234;
      @(posedge clk);
      #1;
      start = 1'b0; hi_we = 1'b0;
      finish_op("busy_ignore", 5);
      quiet("no_queue", 40);

      // MT write coinciding with accepted start is later overwritten
      hi_we = 1'b1; wdata = 32'h77;
      push(32'd0, 32'd6);
      start_op(3'd1, 32'd2, 32'd3);
      hi_we = 1'b0;
      chk("mt_with_start_hi", hi, 32'h77);
      finish_op("mt_with_start", 0);

      // MTLO, then MTHI+MTLO together, in IDLE
      @(posedge clk);
      #1;
      lo_we = 1'b1; wdata = 32'hABCD;
      @(posedge clk);
      #1;
      lo_we = 1'b0;
      chk("mtlo_lo", lo, 32'hABCD);
      chk("mtlo_hi", hi, 32'd0);
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55;
      @(posedge clk);
      #1;
      hi_we = 1'b0; lo_we = 1'b0;
      chk("mt_both_hi", hi, 32'h55);
      chk("mt_both_lo", lo, 32'h55);

      // Asynchronous reset mid-operation
      start_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_busy", busy, 0);
      chk("async_rst_done", done, 0);
      chk("async_rst_hi", hi, 0);
      chk("async_rst_lo", lo, 0);
      @(negedge clk);
      rst_n = 1'b1;
      push(32'd0, 32'd42);
      start_op(3'd1, 32'd6, 32'd7);
      finish_op("after_rst", 0);

      // Illegal ops 6 and 7
      for (int k = 6; k < 8; k++) begin
         start = 1'b1; op = 3'(k); rs_data = 32'd9; rt_data = 32'd9;
         @(posedge clk);
         #1;
         start = 1'b0;
         chk($sformatf("illegal%0d_busy", k), busy, 0);
         quiet($sformatf("illegal%0d", k), 40);
         chk($sformatf("illegal%0d_lo", k), lo, 32'd42);
      end

`ifdef MDU_MADD_EN
      lo_we = 1'b1; wdata = 32'd5;
      @(posedge clk);
      #1;
      lo_we = 1'b0;
      push(32'd0, 32'd47);
      start_op(3'd5, 32'd6, 32'd7);
      finish_op("maddu", 0);
      push(32'd0, 32'd26);
      start_op(3'd4, 32'hFFFFFFF9, 32'd3);
      finish_op("madd", 0);
`else
      start = 1'b1; op = 3'd5; rs_data = 32'd6; rt_data = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("maddu_off_busy", busy, 0);
      quiet("maddu_off", 40);
      chk("maddu_off_hi", hi, 32'd0);
      chk("maddu_off_lo", lo, 32'd42);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
